// File: rtl/snap_fe_pkg.sv
// Shared definitions for the snapshot trigger front-end: FSM states,
// default widths and the order in which the two channels are packed.
package snap_fe_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMED    = 2'd1,
    HOLDOFF  = 2'd2
  } trig_state_t;

  localparam int DIN_WIDTH_DEF     = 16;
  localparam int DEC_WIDTH_DEF     = 16;
  localparam int HOLDOFF_WIDTH_DEF = 16;

  // Channel B occupies the upper half of each packed output word.
  localparam bit PACK_B_HIGH = 1'b1;

endpackage

// File: rtl/snap_trigger_frontend_if.sv
// Sample-pair input stream and packed-word output stream of the front-end.
interface snap_trigger_frontend_if #(
  parameter int DIN_WIDTH = 16
);
  logic signed [DIN_WIDTH-1:0]   din_a;
  logic signed [DIN_WIDTH-1:0]   din_b;
  logic                          din_valid;
  logic        [2*DIN_WIDTH-1:0] dout;
  logic                          dout_valid;
  logic                          trigger;

  modport master (
    output din_a, din_b, din_valid,
    input  dout, dout_valid, trigger
  );

  modport slave (
    input  din_a, din_b, din_valid,
    output dout, dout_valid, trigger
  );
endinterface

// File: rtl/snap_xing_detect.sv
// Combinational level-crossing test of one channel against a signed threshold.
module snap_xing_detect #(
  parameter int DIN_WIDTH = 16
) (
  input  logic signed [DIN_WIDTH-1:0] prev,
  input  logic signed [DIN_WIDTH-1:0] cur,
  input  logic signed [DIN_WIDTH-1:0] thresh,
  input  logic                        trig_edge,
  output logic                        xing
);

  logic rise;
  logic fall;

  // Rising needs prev below and cur at/above the level; falling is the mirror.
  always_comb begin
    rise = (prev < thresh) && (cur >= thresh);
    fall = (prev >= thresh) && (cur < thresh);
    xing = trig_edge ? fall : rise;
  end

endmodule

// File: rtl/snap_trigger_frontend.sv
// Decimating two-channel packer with a level-crossing trigger FSM and holdoff.
// Trigger is registered alongside the kept word so it lines up with dout_valid.
module snap_trigger_frontend
  import snap_fe_pkg::*;
#(
  parameter int DIN_WIDTH     = DIN_WIDTH_DEF,
  parameter int DEC_WIDTH     = DEC_WIDTH_DEF,
  parameter int HOLDOFF_WIDTH = HOLDOFF_WIDTH_DEF
) (
  input  logic                            fpga_clk,
  input  logic                            rst_n,
  snap_trigger_frontend_if.slave          bus,
  input  logic        [DEC_WIDTH-1:0]     decimation,
  input  logic signed [DIN_WIDTH-1:0]     thresh,
  input  logic                            trig_ch,
  input  logic                            trig_edge,
  input  logic        [HOLDOFF_WIDTH-1:0] holdoff,
  input  logic                            trig_en,
  output logic        [31:0]              trig_count
);

  trig_state_t                  state_q, state_d;
  logic [DEC_WIDTH-1:0]         dec_cnt_q, dec_cnt_d, dec_lim;
  logic [HOLDOFF_WIDTH-1:0]     hcnt_q, hcnt_d;
  logic [2*DIN_WIDTH-1:0]       dout_q, dout_d;
  logic                         dout_valid_q, dout_valid_d;
  logic                         trigger_q, trigger_d;
  logic [31:0]                  trig_count_q, trig_count_d;
  logic                         prev_valid_q, prev_valid_d;
  logic                         trig_ch_q;
  logic signed [DIN_WIDTH-1:0]  prev_sel_q;
  logic signed [DIN_WIDTH-1:0]  cur_sel;
  logic                         keep, xing, xing_ok, ch_changed, trig_out;

  snap_xing_detect #(.DIN_WIDTH(DIN_WIDTH)) u_xing (
    .prev      (prev_sel_q),
    .cur       (cur_sel),
    .thresh    (thresh),
    .trig_edge (trig_edge),
    .xing      (xing)
  );

  // Decimation counter, word packing and crossing qualification.
  always_comb begin
    dec_lim    = (decimation == '0) ? '0 : decimation - DEC_WIDTH'(1);
    keep       = bus.din_valid && (dec_cnt_q >= dec_lim);
    dec_cnt_d  = dec_cnt_q;
    if (bus.din_valid) dec_cnt_d = keep ? '0 : dec_cnt_q + DEC_WIDTH'(1);
    cur_sel    = trig_ch ? bus.din_b : bus.din_a;
    ch_changed = (trig_ch != trig_ch_q);
    xing_ok    = keep && prev_valid_q && !ch_changed && xing;
    dout_d     = dout_q;
    if (keep) dout_d = PACK_B_HIGH ? {bus.din_b, bus.din_a} : {bus.din_a, bus.din_b};
    dout_valid_d = keep;
  end

  // Trigger FSM: next state, holdoff counter and the fire decision.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    trigger_d = 1'b0;
    case (state_q)
      DISABLED: if (trig_en) state_d = ARMED;
      ARMED: begin
        if (!trig_en) begin
          state_d = DISABLED;
        end else if (xing_ok) begin
          trigger_d = 1'b1;
          if (holdoff != '0) begin
            hcnt_d  = holdoff;
            state_d = HOLDOFF;
          end
        end
      end
      HOLDOFF: begin
        if (!trig_en) begin
          state_d = DISABLED;
        end else if (keep) begin
          hcnt_d = hcnt_q - HOLDOFF_WIDTH'(1);
          if (hcnt_q == HOLDOFF_WIDTH'(1)) state_d = ARMED;
        end
      end
      default: state_d = DISABLED;
    endcase
  end

  // Previous-sample validity and the trigger counter; arming forgets history.
  always_comb begin
    prev_valid_d = prev_valid_q;
    if (state_q == DISABLED && trig_en) prev_valid_d = 1'b0;
    else if (keep)                      prev_valid_d = 1'b1;
    else if (ch_changed)                prev_valid_d = 1'b0;
    trig_out     = trigger_q && trig_en;
    trig_count_d = trig_count_q + {31'd0, trig_out};
  end

  // Control and output registers.
  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DISABLED;
      dec_cnt_q    <= '0;
      hcnt_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      trigger_q    <= 1'b0;
      trig_count_q <= '0;
      prev_valid_q <= 1'b0;
      trig_ch_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dec_cnt_q    <= dec_cnt_d;
      hcnt_q       <= hcnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      trigger_q    <= trigger_d;
      trig_count_q <= trig_count_d;
      prev_valid_q <= prev_valid_d;
      trig_ch_q    <= trig_ch;
    end
  end

  // Previous selected-channel sample; only meaningful while prev_valid_q is set.
  always_ff @(posedge fpga_clk) begin
    if (keep) prev_sel_q <= cur_sel;
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.trigger    = trig_out;
  assign trig_count     = trig_count_q;

endmodule

// File: doc/snap_trigger_frontend.md
Name: snap_trigger_frontend

Overview:
Front-end stage directly upstream of the snapshot capture block; it produces that block's din/valid/trigger inputs. It takes two signed ADC channels and decimates them by an integer factor. Each kept sample pair is packed into one 32-bit word. A level-crossing trigger FSM with holdoff raises a one-cycle trigger aligned to the word that caused it. All logic runs in the fpga_clk domain; config inputs are quasi-static and already synchronised to fpga_clk.

Parameters:
DIN_WIDTH, 16, width of each signed channel sample
DEC_WIDTH, 16, width of decimation factor
HOLDOFF_WIDTH, 16, width of holdoff word count

Ports:
fpga_clk  in  1  sole clock
rst_n  in  1  asynchronous, active-low reset
din_a  in  DIN_WIDTH  channel A sample, signed
din_b  in  DIN_WIDTH  channel B sample, signed
din_valid  in  1  input sample pair valid
decimation  in  DEC_WIDTH  keep 1 of N valid pairs; 0 treated as 1
thresh  in  DIN_WIDTH  signed trigger level
trig_ch  in  1  0 = trigger on A, 1 = trigger on B
trig_edge  in  1  0 = rising crossing, 1 = falling crossing
holdoff  in  HOLDOFF_WIDTH  number of output words ignored after a trigger
trig_en  in  1  level; 1 arms the trigger FSM
dout  out  2*DIN_WIDTH  packed word, {din_b, din_a} (B in the upper half)
dout_valid  out  1  one-cycle strobe per kept word
trigger  out  1  one-cycle pulse coincident with dout_valid of the crossing word
trig_count  out  32  triggers fired since reset, wraps

Behaviour:
- Reset (rst_n=0, async): dout=0, dout_valid=0, trigger=0, trig_count=0, dec_cnt=0, prev_valid=0, state=DISABLED.
- Decimation: dec_cnt increments on each din_valid.
  - Keep the current pair when dec_cnt >= max(decimation,1)-1, then clear dec_cnt. Using >= means a mid-run reduction of decimation emits on the next valid.
  - Keep = registered: dout/dout_valid appear exactly 1 cycle after the accepted din_valid. No averaging.
  - din_valid=0 holds all state; dout_valid=0.
- Crossing detect, evaluated only on kept words. cur = selected channel of the kept pair; prev = selected channel of the previous kept word.
  - Rising: prev < thresh and cur >= thresh. Falling: prev >= thresh and cur < thresh. Signed compare.
  - Requires prev_valid=1. prev_valid is set by any kept word. It is cleared on reset, on entry to ARMED from DISABLED, and when trig_ch changes.
- FSM states DISABLED, ARMED, HOLDOFF:
  - DISABLED: trigger=0. Goes to ARMED the cycle after trig_en=1 is seen.
  - ARMED: on a kept word with a crossing, assert trigger with that word's dout_valid and increment trig_count. If holdoff=0, stay ARMED; otherwise load hcnt=holdoff and go to HOLDOFF.
  - HOLDOFF: each kept word decrements hcnt, and crossings are ignored. Go to ARMED when hcnt reaches 0, so the (holdoff+1)-th word after the trigger word is the first eligible. prev keeps tracking during HOLDOFF.
  - trig_en=0 in any state: go to DISABLED next cycle. trigger is gated 0 combinationally in that same cycle.
- Simultaneous events:
  - trig_en falling in the same cycle as a crossing: no trigger, no count.
  - decimation change in the same cycle as din_valid: compare against the new value.
- trig_count wraps 0xFFFFFFFF -> 0.
- Config inputs (thresh, trig_edge, holdoff) are sampled when a word is kept; changing them mid-HOLDOFF does not reload hcnt.

Decomposition:
- Package snap_fe_pkg: FSM state enum (DISABLED=2'd0, ARMED=2'd1, HOLDOFF=2'd2), default widths, and the packing order constant (B high).
- One sub-module, snap_xing_detect: combinational signed compare of prev/cur against thresh with edge select. Keeps the FSM file focused on sequencing.

Test Plan:
- Decimation: decimation=4, 12 consecutive din_valid -> dout_valid on cycles after valids 4, 8, 12 only; dout={b,a} of those pairs. decimation=0 -> every valid emits.
- Rising trigger: decimation=1, trig_ch=0, thresh=100, A ramp 90,95,99,100,105 -> single trigger with the word where A=100; trig_count=1. B stays below thresh throughout.
- Falling on B with holdoff=2: B = 200,50,200,50,200,50, thresh=100, trig_edge=1 -> triggers on words 2 and 6 only (words 3-4 held off, 5 rises); trig_count=2.
- First word / re-arm: trig_en rises while A is already below thresh, then first kept A=150 -> no trigger (prev_valid=0). Second word 90 then 150 -> trigger on the 150 word.
- trig_en dropped in the crossing cycle -> trigger=0, count unchanged. rst_n asserted mid-HOLDOFF -> all outputs 0 immediately, state DISABLED.
- Mid-run decimation 8->2 with dec_cnt=5 -> emission on the next din_valid, then every 2.
